// File: rtl/tdm_demux_rx_if.sv
// rtl/tdm_demux_rx_if.sv - TDM receive lane and published-frame bundle
interface tdm_demux_rx_if #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int FCW  = 16
);
    localparam int SW = $clog2(N_CH);

    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] ch_data;
    logic              frame_valid;
    logic [SW-1:0]     slot_idx;
    logic              locked;
    logic              sync_err;
    logic [FCW-1:0]    frame_cnt;

    // TDM link side: drives the lane, observes the published frame
    modport master (
        output din, din_valid, frame_sync,
        input  ch_data, frame_valid, slot_idx, locked, sync_err, frame_cnt
    );

    // Demultiplexer side
    modport slave (
        input  din, din_valid, frame_sync,
        output ch_data, frame_valid, slot_idx, locked, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - receive-side TDM demultiplexer with frame-sync lock
module tdm_demux_rx #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int FCW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    tdm_demux_rx_if.slave    bus
);
    localparam int SW = $clog2(N_CH);
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    typedef enum logic [0:0] {HUNT, RUN} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   slot, slot_nx;
    logic            stg_we;
    logic [SW-1:0]   stg_sel;
    logic            publish;
    logic            err_nx;
    logic [W-1:0]    stg [N_CH];
    logic [N_CH*W-1:0] frame_nx;

    // State and slot pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            slot  <= '0;
        end else begin
            state <= state_nx;
            slot  <= slot_nx;
        end
    end

    // Framing decisions: only accepted samples move the FSM or touch staging
    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        stg_we   = 1'b0;
        stg_sel  = slot;
        publish  = 1'b0;
        err_nx   = 1'b0;
        if (bus.din_valid) begin
            case (state)
                HUNT: begin
                    // Unsynced samples are dropped silently while hunting
                    if (bus.frame_sync) begin
                        stg_we   = 1'b1;
                        stg_sel  = '0;
                        slot_nx  = SW'(1);
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (bus.frame_sync) begin
                        // Early sync abandons the partial frame but resyncs here
                        err_nx  = (slot != '0);
                        stg_we  = 1'b1;
                        stg_sel = '0;
                        slot_nx = SW'(1);
                    end else if (slot == '0) begin
                        // Expected channel-0 marker missing: lose lock
                        err_nx   = 1'b1;
                        slot_nx  = '0;
                        state_nx = HUNT;
                    end else begin
                        stg_we  = 1'b1;
                        stg_sel = slot;
                        if (slot == LAST) begin
                            publish = 1'b1;
                            slot_nx = '0;
                        end else begin
                            slot_nx = slot + SW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                    slot_nx  = '0;
                end
            endcase
        end
    end

    // Per-channel staging slots, written only by accepted samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                stg[k] <= '0;
            end
        end else if (stg_we) begin
            stg[stg_sel] <= bus.din;
        end
    end

    // Frame image at publish time; the last channel bypasses staging
    always_comb begin
        frame_nx = '0;
        for (int k = 0; k < N_CH - 1; k++) begin
            frame_nx[k*W +: W] = stg[k];
        end
        frame_nx[(N_CH-1)*W +: W] = bus.din;
    end

    // Published frame, pulses and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ch_data     <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
            bus.frame_cnt   <= '0;
        end else begin
            bus.frame_valid <= publish;
            bus.sync_err    <= err_nx;
            if (publish) begin
                bus.ch_data   <= frame_nx;
                bus.frame_cnt <= bus.frame_cnt + FCW'(1);
            end
        end
    end

    assign bus.slot_idx = slot;
    assign bus.locked   = (state == RUN);

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive-side time-division demultiplexer. It is the far end of the team's mux-based TDM serializer.
- Accepts one sample per valid cycle from a shared W-bit lane. A frame-sync flag marks the channel-0 sample.
- Steers each sample into its per-channel slot, then publishes a complete frame in parallel with a one-cycle valid pulse.
- Sits between the TDM link and the per-channel consumers.

Parameters:
- N_CH, 4, number of channels per frame; legal range 2..16.
- W, 8, sample width in bits.
- FCW, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  TDM sample lane.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; the current sample is channel 0.
- ch_data  output  N_CH*W  published frame; channel k at bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse: ch_data has just updated.
- slot_idx  output  clog2(N_CH)  slot the next accepted sample will fill.
- locked  output  1  1 when in RUN state.
- sync_err  output  1  one-cycle pulse on a framing violation.
- frame_cnt  output  FCW  count of frames published; wraps modulo 2^FCW.

Behaviour:
Reset (asynchronous, takes effect immediately):
- ch_data=0, frame_valid=0, slot_idx=0, locked=0, sync_err=0, frame_cnt=0.
- Internal staging slots=0; state=HUNT.

Cycles without din_valid:
- No state change. frame_sync and din are ignored. frame_valid and sync_err read 0.

FSM, state HUNT:
- Accepted samples without frame_sync are discarded; no error is raised.
- din_valid&&frame_sync: store din in staging slot 0, slot_idx<=1, go to RUN.

FSM, state RUN, din_valid && !frame_sync:
- slot_idx!=0: store din in staging[slot_idx].
- If slot_idx==N_CH-1 (last slot): on the same edge copy all staging slots to ch_data, with the last slot taken directly from din. Then set slot_idx<=0, frame_valid<=1, frame_cnt<=frame_cnt+1.
- Otherwise: slot_idx<=slot_idx+1.
- slot_idx==0 (expected sync missing): sync_err<=1, discard the sample, go to HUNT, slot_idx<=0.

FSM, state RUN, din_valid && frame_sync:
- slot_idx==0: normal frame start. Store din in slot 0, slot_idx<=1.
- slot_idx!=0 (early sync): sync_err<=1 and discard the partial frame, so ch_data is unchanged and there is no frame_valid. Resync on this sample: store in slot 0, slot_idx<=1, stay in RUN.

Timing:
- frame_valid and sync_err are registered. Each is high for exactly the one cycle after the triggering edge.
- Latency from the last sample's din_valid edge to frame_valid high is 1 cycle.
- ch_data is stable from the frame_valid cycle until the next publish.

Frame completion and wrap:
- Back-to-back frames at full rate (din_valid held high) are sustained with zero gaps. frame_valid then pulses every N_CH cycles.
- frame_cnt wraps from 2^FCW-1 to 0 without an error flag.

Reset during operation:
- Assertion mid-frame clears the partial frame and returns to HUNT.
- The first frame after reset requires a fresh frame_sync.

Sampling rules:
- slot_idx uses clog2(N_CH) bits. For non-power-of-2 N_CH it never exceeds N_CH-1.
- Staging slots are written only by accepted samples. No X propagates from din when din_valid=0.

Test Plan:
1. Reset, then N_CH=4, W=8, sync on the first of 0x11,0x22,0x33,0x44, all din_valid=1. Required: frame_valid high 1 cycle after 0x44, ch_data=0x44332211, frame_cnt=1, locked=1, sync_err never high.
2. Full-rate stream of 3 back-to-back frames with sync every 4th sample. Required: frame_valid pulses exactly every 4 cycles, frame_cnt=3, ch_data matches each frame.
3. Same frame with din_valid toggling 1/0 between samples. Required: identical ch_data; frame_valid 1 cycle after the last valid sample.
4. Early sync: samples 0xA0(sync),0xA1 then 0xB0(sync),0xB1,0xB2,0xB3. Required: sync_err pulses on the cycle after 0xB0, then ch_data=0xB3B2B1B0 with one frame_valid, frame_cnt=1.
5. Missing sync: after a good frame, the next sample 0x55 arrives without sync. Required: sync_err pulse, locked=0. Four unsynced samples are discarded silently with no sync_err. The next synced frame publishes normally.
6. Assert rst with slot_idx=2 mid-frame. Required: all outputs go to 0 immediately, without waiting for a clock edge. After release, unsynced samples are ignored until frame_sync; frame_cnt restarts from 0. Also preload frame_cnt to 0xFFFF via 65535 frames or a force, then publish one more frame. Required: frame_cnt=0.
